// File: rtl/huffman_serializer.sv
// Fixed-table prefix-code serializer: accepts a Col-byte word and emits each byte's code
// MSB first, one bit per cycle, with back-to-back words allowed on the final bit.
module huffman_serializer #(
  parameter int unsigned Col = 8,
  parameter int unsigned Bw  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Col*Bw-1:0] data_in_i,
  input  logic              data_in_valid_i,
  output logic              in_ready_o,
  output logic              data_out_o,
  output logic              data_out_valid_o,
  output logic              data_out_last_o,
  output logic              busy_o,
  output logic [10:0]       address_o
);

  localparam int unsigned W  = Col * Bw;
  localparam int unsigned KW = (Col > 1) ? $clog2(Col) : 1;
  localparam logic [KW-1:0] KLast = KW'(Col - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [9:0]    sr_q, sr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  logic [10:0]   addr_q, addr_d;
  logic          ready_en_q;

  // Returns {length[3:0], code[9:0]} with the code left-aligned.
  function automatic logic [13:0] encode(input logic [7:0] b);
    if (b == 8'h00) begin
      return {4'd1, 10'b0};
    end else if (b[7:4] == 4'h0) begin
      return {4'd6, 2'b10, b[3:0], 4'b0};
    end else begin
      return {4'd10, 2'b11, b};
    end
  endfunction

  logic [13:0] enc_in, enc_next;
  logic        last_bit, transfer;

  assign enc_in   = encode(data_in_i[W-1 -: 8]);
  assign enc_next = encode(word_q[W-1 -: 8]);
  assign last_bit = (state_q == StShift) && (cnt_q == 4'd1) && (k_q == KLast);

  // ready_en_q keeps in_ready low during reset and until the first edge after release.
  assign in_ready_o       = ready_en_q && ((state_q == StIdle) || last_bit);
  assign transfer         = data_in_valid_i && in_ready_o;
  assign busy_o           = (state_q == StShift);
  assign data_out_valid_o = busy_o;
  assign data_out_o       = busy_o & sr_q[9];
  assign data_out_last_o  = last_bit;
  assign address_o        = addr_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (cnt_q == 4'd1) begin
          if (k_q == KLast) begin
            state_d = StIdle;
            k_d     = '0;
            sr_d    = '0;
            cnt_d   = '0;
          end else begin
            k_d    = k_q + KW'(1);
            sr_d   = enc_next[9:0];
            cnt_d  = enc_next[13:10];
            word_d = word_q << Bw;
          end
        end else begin
          sr_d  = {sr_q[8:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (transfer) begin
      state_d = StShift;
      k_d     = '0;
      sr_d    = enc_in[9:0];
      cnt_d   = enc_in[13:10];
      word_d  = data_in_i << Bw;
      addr_d  = addr_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      k_q        <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      addr_q     <= 11'h7FF;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/huffman_serializer.md
HUFFMAN_SERIALIZER -- requirements
Module: huffman_serializer

Interface
REQ-001 Parameter col, default 8: bytes per input word.
REQ-002 Parameter bw, default 8: bits per byte; only bw=8 is supported.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  col*bw  word to encode; byte 0 = data_in[col*bw-1 -: 8], byte col-1 = data_in[7:0].
REQ-006 data_in_valid  input  1  word offer; a word transfers on posedge clk when data_in_valid && in_ready.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 data_out  output  1  serial encoded bit.
REQ-009 data_out_valid  output  1  data_out carries a valid bit this cycle.
REQ-010 data_out_last  output  1  marks the final bit of the current word.
REQ-011 busy  output  1  a word is being serialized.
REQ-012 address  output  11  index of the most recently accepted word.

Function
REQ-013 The code table SHALL be fixed, prefix-free, and emitted MSB first:
- value 0x00 -> "0" (1 bit)
- values 0x01-0x0F -> "10" + value[3:0] (6 bits)
- values 0x10-0xFF -> "11" + value[7:0] (10 bits)
REQ-014 States SHALL be:
- IDLE
- SHIFT (emitting the bits of byte index k, 0..col-1)
REQ-015 Transfer from IDLE: state -> SHIFT with k=0, and the shift register is loaded with the code for byte 0.
REQ-016 Timing: the first bit SHALL appear on data_out, with data_out_valid=1, in the cycle after the transfer edge (latency 1).
REQ-017 In SHIFT, exactly one bit SHALL be emitted per cycle, with no gap cycles between bytes; the next byte's code is loaded on the edge that ends the current byte's last bit.
REQ-018 Total valid cycles per word SHALL equal the sum of the code lengths of its col bytes (range 8..80 for col=8).
REQ-019 data_out_last SHALL be 1 only during the last bit of byte col-1.
REQ-020 in_ready SHALL be 1 in IDLE and during the data_out_last cycle; otherwise 0.
REQ-021 Back-to-back: a transfer during the data_out_last cycle SHALL start the next word's first bit in the very next cycle, with no idle bit.
REQ-022 Last bit with no transfer: state -> IDLE, and data_out_valid=0 in the following cycle.
REQ-023 data_in_valid while in_ready=0 SHALL be ignored; the captured word SHALL not change mid-serialization even if data_in changes.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 data_out SHALL be 0 whenever data_out_valid=0.
REQ-026 address SHALL increment by 1, modulo 2048, on every transfer edge, so the first word after reset reads 0; 2047 wraps to 0.

Reset
REQ-027 While reset=0, the following SHALL hold asynchronously and regardless of clk:
- state=IDLE, k=0, shift register cleared
- data_out=0, data_out_valid=0, data_out_last=0, busy=0
- in_ready=0
- address=11'h7FF
REQ-028 Reset asserted mid-word SHALL abort the word with no further bits emitted; the first transfer after release SHALL start at byte 0.
REQ-029 in_ready SHALL become 1 on the first posedge clk after reset deasserts.

Verification
REQ-030 Word 64'h0 -> 8 valid cycles of data_out=0; data_out_last on the 8th; address=0.
REQ-031 Word 64'h0102030405060708 -> 48 valid bits; the first 6 are 100001 and the last 6 are 101000; address=0.
REQ-032 Word 64'hA5A5A5A5A5A5A5A5 -> 80 bits made of 1110100101 repeated 8 times; busy high for exactly 80 cycles.
REQ-033 Words 64'h0 then 64'hFF00000000000000 offered back-to-back -> 8 + 17 contiguous valid bits with no gap; address goes 0 then 1; in_ready pulses during each data_out_last cycle.
REQ-034 Reset pulsed low during bit 20 of the REQ-032 word -> outputs clear immediately and address=11'h7FF; a new 64'h0 word yields 8 bits and address=0.
REQ-035 2049 consecutive words -> address sequence 0..2047, then 0; no bit lost across the wrap.
